// File: rtl/mem_arbiter_if.sv
// Requester-side memory handshake for mem_arbiter.
//   req   : request, held with stable we/addr/wdata until done
//   we    : 1 = write, 0 = read
//   addr  : 32-bit byte address
//   wdata : write data
//   done  : one-cycle completion pulse
//   err   : valid with done, 1 = access rejected
//   rdata : read data, valid with done on a successful read, held afterwards
// Modports: master = requester (core / loader), slave = arbiter.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input done, err, rdata);
  modport slave  (input req, we, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port word-addressed RAM.
// Serialises one transaction at a time, maps byte addresses to 10-bit word
// addresses and rejects misaligned / out-of-range accesses without a RAM cycle.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   m0 / m1      : requester ports (core / loader), slave modport
//   o_ram_addr   : RAM word address (byte addr[11:2])
//   o_ram_din    : RAM write data
//   o_ram_we     : RAM write enable, high only in the ISSUE cycle of a write
//   i_ram_dout   : RAM read data, valid READ_LATENCY cycles after address capture
module mem_arbiter #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  output logic [9:0]         o_ram_addr,
  output logic [31:0]        o_ram_din,
  output logic               o_ram_we,
  input  logic [31:0]        i_ram_dout
);

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state,      w_state;
  logic               r_grant,      w_grant;
  logic               r_last_grant, w_last_grant;
  logic               r_is_wr,      w_is_wr;
  logic [CNT_W-1:0]   r_cnt,        w_cnt;
  logic [AW-1:0]      r_ram_addr,   w_ram_addr;
  logic [DW-1:0]      r_ram_din,    w_ram_din;
  logic               r_ram_we,     w_ram_we;
  logic [1:0]         r_done,       w_done;
  logic [1:0]         r_err,        w_err;
  logic [DW-1:0]      r_rdata0,     w_rdata0;
  logic [DW-1:0]      r_rdata1,     w_rdata1;

  logic               w_pick;
  logic               w_sel_we;
  logic [31:0]        w_sel_addr;
  logic [DW-1:0]      w_sel_wdata;
  logic               w_bad;

  // On a tie the port not served last wins; otherwise the lone requester.
  assign w_pick      = (m0.req && m1.req) ? ~r_last_grant : m1.req;
  assign w_sel_we    = w_pick ? m1.we    : m0.we;
  assign w_sel_addr  = w_pick ? m1.addr  : m0.addr;
  assign w_sel_wdata = w_pick ? m1.wdata : m0.wdata;
  assign w_bad       = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr[31:12] != 20'd0);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_is_wr      <= 1'b0;
      r_cnt        <= '0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_ram_we     <= 1'b0;
      r_done       <= '0;
      r_err        <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state;
      r_grant      <= w_grant;
      r_last_grant <= w_last_grant;
      r_is_wr      <= w_is_wr;
      r_cnt        <= w_cnt;
      r_ram_addr   <= w_ram_addr;
      r_ram_din    <= w_ram_din;
      r_ram_we     <= w_ram_we;
      r_done       <= w_done;
      r_err        <= w_err;
      r_rdata0     <= w_rdata0;
      r_rdata1     <= w_rdata1;
    end
  end

  // Next-state and next-output logic; done/err are computed one cycle early so
  // the registered pulse lines up with the DONE state.
  always_comb begin
    w_state      = r_state;
    w_grant      = r_grant;
    w_last_grant = r_last_grant;
    w_is_wr      = r_is_wr;
    w_cnt        = r_cnt;
    w_ram_addr   = r_ram_addr;
    w_ram_din    = r_ram_din;
    w_ram_we     = 1'b0;
    w_done       = '0;
    w_err        = '0;
    w_rdata0     = r_rdata0;
    w_rdata1     = r_rdata1;

    case (r_state)
      S_IDLE: begin
        if (m0.req || m1.req) begin
          w_grant = w_pick;
          w_is_wr = w_sel_we;
          if (w_bad) begin
            w_state        = S_DONE;
            w_done[w_pick] = 1'b1;
            w_err[w_pick]  = 1'b1;
          end else begin
            w_state    = S_ISSUE;
            w_ram_addr = w_sel_addr[11:2];
            w_ram_din  = w_sel_wdata;
            w_ram_we   = w_sel_we;
          end
        end
      end

      S_ISSUE: begin
        if (r_is_wr) begin
          w_state         = S_DONE;
          w_done[r_grant] = 1'b1;
        end else begin
          w_state = S_WAIT;
          w_cnt   = CNT_W'(READ_LATENCY - 1);
        end
      end

      // Last WAIT cycle: RAM data is valid, capture it with the done pulse.
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state         = S_DONE;
          w_done[r_grant] = 1'b1;
          if (r_grant) w_rdata1 = i_ram_dout;
          else         w_rdata0 = i_ram_dout;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        w_last_grant = r_grant;
        w_state      = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign m0.done    = r_done[0];
  assign m0.err     = r_err[0];
  assign m0.rdata   = r_rdata0;
  assign m1.done    = r_done[1];
  assign m1.err     = r_err[1];
  assign m1.rdata   = r_rdata1;

  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_ram_we   = r_ram_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// completions; a negedge monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  localparam int unsigned RL0 = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_we = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if u_m0 ();
  mem_arbiter_if u_m1 ();
  mem_arbiter_if u_b0 ();
  mem_arbiter_if u_b1 ();

  logic [1:0]  req_d;
  logic [1:0]  we_d;
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        b_req;
  logic [31:0] b_addr;

  assign u_m0.req   = req_d[0];
  assign u_m0.we    = we_d[0];
  assign u_m0.addr  = addr_d[0];
  assign u_m0.wdata = wdata_d[0];
  assign u_m1.req   = req_d[1];
  assign u_m1.we    = we_d[1];
  assign u_m1.addr  = addr_d[1];
  assign u_m1.wdata = wdata_d[1];

  assign u_b0.req   = b_req;
  assign u_b0.we    = 1'b0;
  assign u_b0.addr  = b_addr;
  assign u_b0.wdata = 32'd0;
  assign u_b1.req   = 1'b0;
  assign u_b1.we    = 1'b0;
  assign u_b1.addr  = 32'd0;
  assign u_b1.wdata = 32'd0;

  wire [1:0]   done_w = {u_m1.done, u_m0.done};
  wire [1:0]   err_w  = {u_m1.err,  u_m0.err};
  logic [31:0] rdata_w [2];
  assign rdata_w[0] = u_m0.rdata;
  assign rdata_w[1] = u_m1.rdata;

  logic [9:0]  ram_addr,  ram1_addr;
  logic [31:0] ram_din,   ram1_din;
  logic [31:0] ram_dout,  ram1_dout;
  logic        ram_we,    ram1_we;

  mem_arbiter #(.READ_LATENCY(RL0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (u_m0),
    .m1         (u_m1),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .o_ram_we   (ram_we),
    .i_ram_dout (ram_dout)
  );

  mem_arbiter #(.READ_LATENCY(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .m0         (u_b0),
    .m1         (u_b1),
    .o_ram_addr (ram1_addr),
    .o_ram_din  (ram1_din),
    .o_ram_we   (ram1_we),
    .i_ram_dout (ram1_dout)
  );

  // RAM models: address captured on the edge, data valid RL cycles later.
  logic [31:0] mem0  [1024];
  logic [31:0] pipe0 [RL0];
  logic [31:0] mem1  [1024];
  logic [31:0] pipe1;

  always @(posedge clk) begin
    if (ram_we) mem0[ram_addr] <= ram_din;
    pipe0[0] <= mem0[ram_addr];
    for (int unsigned i = 1; i < RL0; i++) pipe0[i] <= pipe0[i-1];
  end
  assign ram_dout = pipe0[RL0-1];

  always @(posedge clk) begin
    if (ram1_we) mem1[ram1_addr] <= ram1_din;
    pipe1 <= mem1[ram1_addr];
  end
  assign ram1_dout = pipe1;

  always @(negedge clk) if (ram_we) n_we++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input int p, input logic e, input logic [31:0] d, input int at);
    sb.push_back('{port: p, err: e, rdata: d, at: at});
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (done_w != 2'b00)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done_w, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_port", 32'(done_w), 32'((mon_e.port == 1) ? 2'b10 : 2'b01));
        check("done_err", 32'(err_w), mon_e.err ? 32'((mon_e.port == 1) ? 2'b10 : 2'b01) : 32'd0);
        check("done_rdata", rdata_w[mon_e.port], mon_e.rdata);
        check("done_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
    if (!rst && ((err_w & ~done_w) != 2'b00)) begin
      n_checks++;
      n_errors++;
      $display("FAIL err_without_done: got err=%b done=%b", err_w, done_w);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drive a request until done, then drop req in the following IDLE cycle.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit seen = 1'b0;
    req_d[p]   = 1'b1;
    we_d[p]    = we;
    addr_d[p]  = a;
    wdata_d[p] = d;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done_w[p]) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL txn_timeout: port %0d got no done, expected done", p);
    end
    sync();
    req_d[p] = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    for (int k = 0; k < 200 && cyc < t; k++) @(negedge clk);
    check("wait_cycle", 32'(cyc), 32'(t));
  endtask

  task automatic chk_reset();
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din",  ram_din,       32'd0);
    check("rst_ram_we",   32'(ram_we),   32'd0);
    check("rst_done",     32'(done_w),   32'd0);
    check("rst_err",      32'(err_w),    32'd0);
    check("rst_rdata0",   rdata_w[0],    32'd0);
    check("rst_rdata1",   rdata_w[1],    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int c;
    int w;
    bit seen;
    rst        = 1'b1;
    req_d      = '0;
    we_d       = '0;
    addr_d     = '{32'd0, 32'd0};
    wdata_d    = '{32'd0, 32'd0};
    b_req      = 1'b0;
    b_addr     = 32'd0;
    mem1[5]    = 32'hCAFEF00D;
    sync();
    sync();
    chk_reset();
    rst = 1'b0;

    // Port 0 write then read of 0x10.
    c = cyc;
    push(0, 1'b0, 32'd0, c + 2);
    fork
      txn(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF);
      begin
        wait_cyc(c + 1);
        check("wr_ram_addr", 32'(ram_addr), 32'd4);
        check("wr_ram_we",   32'(ram_we),   32'd1);
        check("wr_ram_din",  ram_din,       32'hDEADBEEF);
      end
    join
    c = cyc;
    push(0, 1'b0, 32'hDEADBEEF, c + 4);
    txn(0, 1'b0, 32'h0000_0010, 32'd0);

    // Port 1 write, leaves last_grant = 1 so port 0 wins the next tie.
    c = cyc;
    push(1, 1'b0, 32'd0, c + 2);
    txn(1, 1'b1, 32'h0000_0044, 32'h12345678);

    // Continuous contention: grants 0,1,0,1, done every 5 cycles.
    c = cyc;
    push(0, 1'b0, 32'hDEADBEEF, c + 4);
    push(1, 1'b0, 32'h12345678, c + 9);
    push(0, 1'b0, 32'h12345678, c + 14);
    push(1, 1'b0, 32'hDEADBEEF, c + 19);
    fork
      begin
        txn(0, 1'b0, 32'h0000_0010, 32'd0);
        txn(0, 1'b0, 32'h0000_0044, 32'd0);
      end
      begin
        txn(1, 1'b0, 32'h0000_0044, 32'd0);
        txn(1, 1'b0, 32'h0000_0010, 32'd0);
      end
    join

    // Rejected accesses on port 1: err in cycle 1, no RAM write, rdata held.
    w = n_we;
    c = cyc;
    push(1, 1'b1, 32'hDEADBEEF, c + 1);
    txn(1, 1'b0, 32'h0000_0002, 32'd0);
    c = cyc;
    push(1, 1'b1, 32'hDEADBEEF, c + 1);
    txn(1, 1'b0, 32'h0000_1000, 32'd0);
    check("err_no_ram_we", 32'(n_we), 32'(w));

    // Back-to-back on port 0 at the top word 0xFFC.
    c = cyc;
    push(0, 1'b0, 32'h12345678, c + 2);
    push(0, 1'b0, 32'hA5A50FFC, c + 7);
    fork
      begin
        txn(0, 1'b1, 32'h0000_0FFC, 32'hA5A50FFC);
        txn(0, 1'b0, 32'h0000_0FFC, 32'd0);
      end
      begin
        wait_cyc(c + 1);
        check("b2b_wr_addr", 32'(ram_addr), 32'h3FF);
        check("b2b_wr_we",   32'(ram_we),   32'd1);
        wait_cyc(c + 4);
        check("b2b_rd_addr", 32'(ram_addr), 32'h3FF);
        check("b2b_rd_we",   32'(ram_we),   32'd0);
      end
    join

    // Reset during WAIT of a port 0 read: no done, everything back to reset.
    req_d[0]  = 1'b1;
    we_d[0]   = 1'b0;
    addr_d[0] = 32'h0000_0010;
    sync();
    sync();
    rst      = 1'b1;
    req_d[0] = 1'b0;
    sync();
    chk_reset();
    rst = 1'b0;
    repeat (6) sync();
    check("rst_wait_rdata0", rdata_w[0], 32'd0);

    // Reset during ISSUE of a write to 0x20: the RAM still commits it.
    req_d[0]   = 1'b1;
    we_d[0]    = 1'b1;
    addr_d[0]  = 32'h0000_0020;
    wdata_d[0] = 32'h0BADF00D;
    sync();
    check("rst_issue_we", 32'(ram_we), 32'd1);
    rst      = 1'b1;
    req_d[0] = 1'b0;
    sync();
    rst = 1'b0;
    check("rst_issue_we_clr", 32'(ram_we), 32'd0);
    c = cyc;
    push(0, 1'b0, 32'h0BADF00D, c + 4);
    txn(0, 1'b0, 32'h0000_0020, 32'd0);

    // READ_LATENCY = 1 instance: read done in cycle 3.
    c      = cyc;
    seen   = 1'b0;
    b_req  = 1'b1;
    b_addr = 32'h0000_0014;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (u_b0.done) seen = 1'b1;
    end
    check("rl1_done_seen", 32'(seen),       32'd1);
    check("rl1_done_cyc",  32'(cyc),        32'(c + 3));
    check("rl1_rdata",     u_b0.rdata,      32'hCAFEF00D);
    check("rl1_err",       32'(u_b0.err),   32'd0);
    sync();
    b_req = 1'b0;

    repeat (4) sync();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, word-addressed program/data RAM between the multicycle core (port 0) and the program loader/debug port (port 1). It serialises one transaction at a time, translates 32-bit byte addresses to the RAM's 10-bit word address, and flags misaligned or out-of-range accesses without touching the RAM. It sits between the core's memory-request logic, the loader and the RAM instance in the top level.

## Interface
- READ_LATENCY, 2, RAM read latency in cycles from the address-capture edge to valid `ram_dout` (legal 1..4).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- m0_req / m1_req  in  1  request; held high with stable attributes until `mX_done`.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  valid with done; 1 = access rejected.
- m0_rdata / m1_rdata  out  32  read data, valid with done on a successful read; held until next read completion on that port.
- ram_addr  out  10  RAM word address (`addr[11:2]`).
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample `m0_req`, `m1_req`. One requester → grant it. Both → round-robin: grant the port not served last. `last_grant` resets to 1 so port 0 wins the first tie. Latch granted port's we/addr/wdata.
- Address check on grant: `addr[1:0] != 0` or `addr[31:12] != 0` → error; go directly to DONE with `err=1`, no RAM access, rdata unchanged.
- Valid access → ISSUE. Registered `ram_addr`, `ram_din`, `ram_we` (we only for writes) are driven during the ISSUE cycle.
- Write: ISSUE → DONE.
- Read: ISSUE → WAIT; WAIT lasts READ_LATENCY cycles (counter); `ram_dout` sampled at the edge ending the last WAIT cycle into the port's rdata register → DONE.
- DONE: pulse granted port's done (and err) for exactly one cycle; update `last_grant`; → IDLE.
- Requester sees done, then may drop req or present a new request in the following (IDLE) cycle; req high in that cycle is a new request.
- A port whose req is not granted stays pending; no starvation: under continuous contention grants alternate 0,1,0,1.
- `ram_we` is 0 in every state except ISSUE of a write. `ram_addr`/`ram_din` hold their last value outside ISSUE.
- Done never asserts on the non-granted port.

## Timing
- Request first sampled in IDLE at cycle 0 (no contention):
  - Write: ISSUE cycle 1, done cycle 2.
  - Read: ISSUE cycle 1, WAIT cycles 2..READ_LATENCY+1, done cycle READ_LATENCY+2 (4 for default).
  - Error: done+err cycle 1.
- Throughput: one write per 3 cycles, one read per READ_LATENCY+3 cycles.
- Reset values: state IDLE, `last_grant`=1, all done/err 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0, both rdata 0.
- Reset mid-operation: next cycle IDLE, no done pulse. Reset during the ISSUE cycle of a write: the RAM still commits that write (`ram_we` already driven at that edge). Reset in WAIT: read data discarded.
- req dropped before done is a protocol violation; the arbiter completes the transaction and pulses done regardless.

## Test plan
- Port 0 write 0xDEADBEEF to 0x0000_0010, then read it: `ram_addr`=4, `ram_we`=1 in cycle 1, done cycle 2; read done cycle 4, `m0_rdata`=0xDEADBEEF, err=0.
- Both req high from reset, each doing reads: grants 0,1,0,1; each done separated by 5 cycles; the other port's done stays 0.
- Port 1 read of 0x0000_0002 (misaligned) and 0x0000_1000 (out of range): done+err in cycle 1 each, `ram_we` never 1, `m1_rdata` unchanged.
- Back-to-back: port 0 keeps req high after done with new address 0x0000_0FFC: new ISSUE follows the IDLE cycle, `ram_addr`=0x3FF.
- rst asserted during WAIT of a port 0 read: no done pulse, all outputs at reset values next cycle. rst during ISSUE of a write to 0x20: a subsequent read of 0x20 returns the written data.
- READ_LATENCY=1 build: read done at cycle 3, data correct.
